// File: rtl/program_loader.sv
// Byte-stream program loader: unpacks a length-prefixed byte stream into instruction
// words, writes them to instruction memory from address 0, and holds the core until done.
module program_loader #(
  parameter int INSTR_WIDTH = 10,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_run,
  output logic                   load_error,
  output logic [8:0]             word_count
);

  localparam int         HI_W  = INSTR_WIDTH - 8;
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {S_COUNT, S_HI, S_LO, S_WRITE, S_RUN, S_ERROR} state_t;

  state_t          state, state_nxt;
  logic [8:0]      n_words;
  logic [HI_W-1:0] hi_bits;
  logic            accept;
  logic [8:0]      count_n;
  logic            count_bad;
  logic            hi_bad;
  logic            count_accept;

  // A high byte may only use its lowest HI_W bits; anything above is a framing error.
  function automatic logic hi_overflow(input logic [7:0] b);
    logic [15:0] w;
    w = {8'h00, b} >> HI_W;
    return w != 16'd0;
  endfunction

  assign accept       = rx_valid & rx_ready;
  assign count_n      = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
  assign count_bad    = count_n > DEPTH;
  assign hi_bad       = hi_overflow(rx_data);
  assign count_accept = accept & ((state == S_COUNT) | (state == S_RUN));

  // All status outputs decode from the registered state, so rx_ready never sees rx_valid.
  assign rx_ready   = (state != S_WRITE);
  assign imem_we    = (state == S_WRITE);
  assign cpu_run    = (state == S_RUN);
  assign load_error = (state == S_ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_COUNT, S_RUN: if (accept) state_nxt = count_bad ? S_ERROR : S_HI;
      S_HI:           if (accept) state_nxt = hi_bad ? S_ERROR : S_LO;
      S_LO:           if (accept) state_nxt = S_WRITE;
      S_WRITE:        state_nxt = (word_count + 9'd1 == n_words) ? S_RUN : S_HI;
      S_ERROR:        state_nxt = S_ERROR;
      default:        state_nxt = S_COUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_COUNT;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (count_accept && !count_bad) begin
        imem_addr  <= '0;
        word_count <= '0;
      end
      if (accept && state == S_LO)
        imem_wdata <= {hi_bits, rx_data};
      if (state == S_WRITE) begin
        imem_addr  <= imem_addr + ADDR_WIDTH'(1);
        word_count <= word_count + 9'd1;
      end
    end
  end

  // Frame bookkeeping is only meaningful once its state has been reached, so it needs no reset.
  always_ff @(posedge clk) begin
    if (count_accept)
      n_words <= count_n;
    if (accept && state == S_HI)
      hi_bits <= rx_data[HI_W-1:0];
  end

endmodule
